// File: rtl/dct_read_sched_if.sv
// Bundle of the scheduler's SRAM read port, DCT output stream and status signals.
// master = the scheduler, slave = the SRAM/DCT environment driving it.
interface dct_read_sched_if;
  logic         enable;
  logic [10:0]  sram_raddr;
  logic         rd_en;
  logic [511:0] sram_rdata;
  logic [511:0] dct_data;
  logic         dct_valid;
  logic         dct_ready;
  logic [1:0]   plane;
  logic [9:0]   blk_idx;
  logic         plane_done;
  logic         frame_done;
  logic         busy;

  modport master (
    input  enable, sram_rdata, dct_ready,
    output sram_raddr, rd_en, dct_data, dct_valid, plane, blk_idx,
           plane_done, frame_done, busy
  );

  modport slave (
    output enable, sram_rdata, dct_ready,
    input  sram_raddr, rd_en, dct_data, dct_valid, plane, blk_idx,
           plane_done, frame_done, busy
  );
endinterface

// File: rtl/dct_read_sched.sv
// Streams one frame (3 planes x 576 blocks, interleaved in SRAM) to the DCT in plane-major order.
// Optional macro DCT_SCHED_BACKPRESSURE_EN: honour dct_ready via a 2-entry credited skid buffer.
module dct_read_sched (
  input  logic                    clk,
  input  logic                    rst_n,
  dct_read_sched_if.master        bus,
  output logic [1:0]              state_dbg
);
  // Handshake: an output block transfers in a cycle where dct_valid and dct_ready are both 1;
  // while dct_valid=1 and dct_ready=0, dct_data/plane/blk_idx hold; sram_rdata follows rd_en by one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [9:0] LAST_BLK   = 10'd575;
  localparam logic [1:0] LAST_PLANE = 2'd2;

  state_t       state, state_nxt;
  logic [10:0]  raddr;
  logic [9:0]   iss_blk;
  logic [1:0]   iss_plane;
  logic         issue, last_issue, credit_ok, hs;
  logic         pend;
  logic [9:0]   pend_blk;
  logic [1:0]   pend_plane;
  logic         out_valid;
  logic [511:0] out_data;
  logic [1:0]   out_plane;
  logic [9:0]   out_blk;

  assign issue      = (state == RUN) && credit_ok;
  assign last_issue = issue && (iss_plane == LAST_PLANE) && (iss_blk == LAST_BLK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.enable) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (hs && out_plane == LAST_PLANE && out_blk == LAST_BLK) state_nxt = DONE;
      DONE:    if (!bus.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address walks +3 within a plane and wraps to the next plane's base; it freezes on the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr     <= '0;
      iss_blk   <= '0;
      iss_plane <= '0;
    end else if (state == IDLE && bus.enable) begin
      raddr     <= '0;
      iss_blk   <= '0;
      iss_plane <= '0;
    end else if (issue && !last_issue) begin
      if (iss_blk == LAST_BLK) begin
        iss_blk   <= '0;
        iss_plane <= iss_plane + 2'd1;
        raddr     <= {9'd0, iss_plane + 2'd1};
      end else begin
        iss_blk <= iss_blk + 10'd1;
        raddr   <= raddr + 11'd3;
      end
    end
  end

  // Tag of the read whose data is on sram_rdata this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_blk   <= '0;
      pend_plane <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_blk   <= iss_blk;
        pend_plane <= iss_plane;
      end
    end
  end

`ifdef DCT_SCHED_BACKPRESSURE_EN
  logic [511:0] fifo_data  [2];
  logic [1:0]   fifo_plane [2];
  logic [9:0]   fifo_blk   [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic [1:0]   credits;

  // A credit freed by this cycle's handshake may be spent by this cycle's read.
  assign credit_ok = (credits != 2'd0) || hs;
  assign out_valid = (count != 2'd0);
  assign hs        = out_valid && bus.dct_ready;

  always_comb begin
    out_data  = fifo_data[rd_ptr];
    out_plane = fifo_plane[rd_ptr];
    out_blk   = fifo_blk[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i]  <= '0;
        fifo_plane[i] <= '0;
        fifo_blk[i]   <= '0;
      end
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      credits <= 2'd2;
    end else begin
      if (pend) begin
        fifo_data[wr_ptr]  <= bus.sram_rdata;
        fifo_plane[wr_ptr] <= pend_plane;
        fifo_blk[wr_ptr]   <= pend_blk;
        wr_ptr             <= ~wr_ptr;
      end
      if (hs) rd_ptr <= ~rd_ptr;
      count   <= count + {1'b0, pend} - {1'b0, hs};
      credits <= credits - {1'b0, issue} + {1'b0, hs};
    end
  end
`else
  // No backpressure: every registered block is consumed the cycle it is shown.
  assign credit_ok = 1'b1;
  assign hs        = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_plane <= '0;
      out_blk   <= '0;
    end else begin
      out_valid <= pend;
      if (pend) begin
        out_data  <= bus.sram_rdata;
        out_plane <= pend_plane;
        out_blk   <= pend_blk;
      end
    end
  end
`endif

  assign bus.rd_en      = issue;
  assign bus.sram_raddr = raddr;
  assign bus.dct_valid  = out_valid;
  assign bus.dct_data   = out_data;
  assign bus.plane      = out_plane;
  assign bus.blk_idx    = out_blk;
  assign bus.plane_done = hs && (out_blk == LAST_BLK);
  assign bus.frame_done = hs && (out_blk == LAST_BLK) && (out_plane == LAST_PLANE);
  assign bus.busy       = (state == RUN) || (state == DRAIN);
  assign state_dbg      = state;
endmodule

// File: doc/dct_read_sched.md
DCT_READ_SCHED -- requirements
Module: dct_read_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  start request, sampled only in IDLE.
REQ-005 sram_raddr  output  11  SRAM read address, 0..1727.
REQ-006 rd_en  output  1  a read is issued this cycle at sram_raddr.
REQ-007 sram_rdata  input  512  SRAM read data, valid the cycle after rd_en.
REQ-008 dct_data  output  512  block data presented to the DCT datapath.
REQ-009 dct_valid  output  1  dct_data is valid.
REQ-010 dct_ready  input  1  the DCT datapath accepts dct_data.
REQ-011 plane  output  2  plane of dct_data: 0 = Y, 1 = Cb, 2 = Cr.
REQ-012 blk_idx  output  10  block index of dct_data within its plane, 0..575.
REQ-013 plane_done  output  1  one-cycle pulse on the last block of a plane.
REQ-014 frame_done  output  1  one-cycle pulse on the last block of the frame.
REQ-015 busy  output  1  high in RUN and DRAIN.

Function
REQ-016 SRAM layout: word address = 3*blk + plane, with blk 0..575 and plane 0..2.
REQ-017 Read order: plane-major, Y first, then Cb, then Cr.
- Addresses issued: 0,3,...,1725, then 1,4,...,1726, then 2,5,...,1727.
REQ-018 Address generation: incremental, +3 per read; at the end of a plane the next address is plane+1; no multiplier.
REQ-019 States SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE->RUN when enable=1.
- RUN->DRAIN in the cycle after the 1728th read is issued.
- DRAIN->DONE when the last output handshake completes.
- DONE->IDLE when enable=0.
REQ-020 enable SHALL be ignored outside IDLE; deasserting it mid-frame does not abort the frame.
REQ-021 Latency: a read issued in cycle t SHALL appear with dct_valid=1 no earlier than cycle t+2, since sram_rdata is registered.
REQ-022 Output handshake: the output transfers when dct_valid and dct_ready are both 1.
- While dct_valid=1 and dct_ready=0, dct_data, plane and blk_idx SHALL hold stable.
REQ-023 Read credits: reads in flight plus buffered outputs SHALL never exceed 2.
- A read may issue in the same cycle an output handshake frees a credit.
REQ-024 Throughput: with dct_ready held at 1, one block per cycle; 1728 handshakes complete in 1728 consecutive cycles after the first dct_valid.
REQ-025 plane and blk_idx SHALL travel with the data, not with the issue counters.
REQ-026 plane_done SHALL pulse coincident with the handshake of blk_idx=575 for each plane, 3 pulses per frame.
REQ-027 frame_done SHALL pulse coincident with the handshake of plane=2, blk_idx=575; plane_done also pulses in that same cycle.
REQ-028 rd_en SHALL be 0 in IDLE, DRAIN and DONE; sram_raddr holds its last value when rd_en=0.

Reset
REQ-029 rst_n=0 SHALL immediately force the following values:
- state IDLE;
- rd_en, dct_valid, plane_done, frame_done, busy = 0;
- sram_raddr, plane, blk_idx = 0;
- dct_data = 0;
- credits = 2, buffer empty.
REQ-030 Reset asserted mid-frame SHALL discard in-flight reads; after release the block restarts only on enable in IDLE.

Configuration
REQ-031 Macro DCT_SCHED_BACKPRESSURE_EN:
- Defined: dct_ready is honored and a 2-entry output skid buffer with credit control is used, per REQ-022..024.
- Undefined: dct_ready is ignored and treated as 1; a single output register is used; one read per cycle in RUN; data is presented exactly 2 cycles after issue.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- enable=1 after reset, dct_ready=1 -> 1728 reads, address sequence 0,3,...,1725,1,...,1727; first dct_valid 2 cycles after first rd_en; frame_done 1729 cycles after first rd_en.
- dct_ready=0 for cycles 10..19 of RUN (macro defined) -> at most 2 reads issued beyond the stall; dct_data stable throughout; no block lost or duplicated.
- Random dct_ready at 50% (macro defined) -> output order plane 0,1,2 with blk_idx 0..575 each; plane_done count 3; frame_done count 1.
- rst_n pulsed low at output handshake 700 -> all outputs 0 asynchronously; re-enable restarts at address 0 with plane=0, blk_idx=0.
- enable dropped mid-frame, then held 1 through DONE -> frame completes; block stays in DONE until enable=0, then returns to IDLE.
- Macro undefined, dct_ready=0 constantly -> full 1728-block stream still emitted, one per cycle.
